// File: rtl/axis_ring_pkg.sv
// Shared sizing helpers for the packet ring: how a wide packet is cut
// into BRAM slices, plus the width of the overflow counter.
package axis_ring_pkg;

  localparam int OVERFLOW_CNT_WIDTH = 32;

  function automatic int ring_slices(input int data_w, input int slice_w);
    return (data_w + slice_w - 1) / slice_w;
  endfunction

  function automatic int slice_lo(input int k, input int slice_w);
    return k * slice_w;
  endfunction

  // The final slice is clipped to the packet width, so it may be narrower.
  function automatic int slice_hi(input int k, input int data_w, input int slice_w);
    int top;
    top = (k + 1) * slice_w;
    if (top > data_w) top = data_w;
    return top - 1;
  endfunction

endpackage

// File: rtl/axis_ring_slice.sv
// One BRAM slice of the packet ring: simple dual-port memory with a
// single write port and a registered synchronous read port.
module axis_ring_slice #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4000,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_packet_ring.sv
// Circular FIFO of wide packets between the difftest packer and the
// AXI-Stream beat serializer, striped across BRAM slices.
module axis_packet_ring
  import axis_ring_pkg::*;
#(
  parameter int DATA_WIDTH  = 16000,
  parameter int NUM_PACKETS = 8,
  parameter int SLICE_WIDTH = 4000,
  localparam int PTR_WIDTH  = $clog2(NUM_PACKETS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [PTR_WIDTH:0]            occupancy,
  output logic [OVERFLOW_CNT_WIDTH-1:0] overflow_cnt
);

  localparam int NUM_SLICES = ring_slices(DATA_WIDTH, SLICE_WIDTH);
  localparam logic [PTR_WIDTH:0] FULL_OCC = (PTR_WIDTH + 1)'(NUM_PACKETS);

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] rd_addr;
  logic [PTR_WIDTH:0]   occ_q, occ_d;
  logic                 out_valid_q, out_valid_d;
  logic [OVERFLOW_CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic                 push, pop, full, avail, wr_en;

  assign full     = (occ_q == FULL_OCC);
  assign in_ready = reset & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid_q & out_ready;
  assign wr_en    = push & ~flush;
  assign rd_addr  = pop ? rd_ptr_q + PTR_WIDTH'(1) : rd_ptr_q;

  // Packets already committed before this edge, minus the one leaving now;
  // a push at this edge is only readable from the next edge on.
  assign avail = (occ_q > (PTR_WIDTH + 1)'(pop));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    if (in_valid && !in_ready && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
      out_valid_d = avail;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    localparam int LO = slice_lo(k, SLICE_WIDTH);
    localparam int HI = slice_hi(k, DATA_WIDTH, SLICE_WIDTH);

    axis_ring_slice #(
      .DEPTH (NUM_PACKETS),
      .WIDTH (HI - LO + 1)
    ) u_slice (
      .clk_i     (clock),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (in_data[HI:LO]),
      .rd_addr_i (rd_addr),
      .rd_data_o (out_data[HI:LO])
    );
  end

  assign out_valid    = out_valid_q;
  assign occupancy    = occ_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_axis_packet_ring.sv
// Directed and random stimulus for axis_packet_ring, checked every cycle
// against a queue model that tracks each packet's push edge.
module tb_axis_packet_ring;

  localparam int DW = 10000;
  localparam int NP = 4;
  localparam int SW = 4000;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    occupancy;
  logic [31:0]   overflow_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } ent_t;

  ent_t        mq[$];
  int          edge_n = 0;
  logic        m_rst_n;
  int unsigned m_ovf;

  axis_packet_ring #(
    .DATA_WIDTH  (DW),
    .NUM_PACKETS (NP),
    .SLICE_WIDTH (SW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rand_pkt();
    logic [10015:0] t;
    for (int i = 0; i < 313; i++) t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  function automatic logic m_ready();
    return m_rst_n && (mq.size() < NP);
  endfunction

  // A packet pushed at edge e is presentable after edge e+1 onward.
  function automatic logic m_valid();
    return m_rst_n && (mq.size() > 0) && (mq[0].e <= edge_n - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] exp);
    total++;
    assert (out_data === exp)
    else begin
      bad++;
      $error("FAIL %s got_lo=%h got_hi=%h exp_lo=%h exp_hi=%h", tag,
             out_data[31:0], out_data[DW-1:DW-32], exp[31:0], exp[DW-1:DW-32]);
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".in_ready"},  {31'd0, in_ready},  {31'd0, m_ready()});
    chk({ph, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid()});
    chk({ph, ".occupancy"}, {29'd0, occupancy}, mq.size());
    chk({ph, ".overflow"},  overflow_cnt,       m_ovf);
    if (m_valid()) chk_data({ph, ".out_data"}, mq[0].d);
  endtask

  task automatic m_clear();
    mq.delete();
  endtask

  task automatic step(input string ph, input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    logic push, pop;
    ent_t ent;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    check_outputs(ph);
    push = iv && m_ready();
    pop  = m_valid() && ordy;
    @(posedge clock);
    edge_n++;
    if (iv && !m_ready() && m_ovf != 32'hFFFF_FFFF) m_ovf++;
    if (fl) begin
      m_clear();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        ent.d = d;
        ent.e = edge_n;
        mq.push_back(ent);
      end
    end
    #1;
  endtask

  logic [DW-1:0] pat;

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    m_rst_n   = 1'b0;
    m_ovf     = 0;
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset_hold");
    reset   = 1'b1;
    m_rst_n = 1'b1;
    #1;
    check_outputs("release");

    // Single packet, latency 2, full 10000-bit compare.
    pat = rand_pkt();
    step("single_push", 1'b1, pat, 1'b1, 1'b0);
    repeat (3) step("single_drain", 1'b0, '0, 1'b1, 1'b0);

    // Fill, stall with in_valid held (overflow 3), head held stable.
    for (int i = 0; i < NP; i++) step("fill", 1'b1, rand_pkt(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("overflow", 1'b1, rand_pkt(), 1'b0, 1'b0);
    step("full_idle", 1'b0, '0, 1'b0, 1'b0);

    // Back-to-back drain of the full ring.
    for (int i = 0; i < NP + 2; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

    // Continuous push/pop wrapping the pointers.
    for (int i = 0; i < 20; i++) step("stream", 1'b1, rand_pkt(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("stream_tail", 1'b0, '0, 1'b1, 1'b0);

    // Flush with three stored, coincident with a push.
    for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, rand_pkt(), 1'b0, 1'b0);
    step("pre_flush_idle", 1'b0, '0, 1'b0, 1'b0);
    step("flush_push", 1'b1, rand_pkt(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("post_flush", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with two stored.
    for (int i = 0; i < 2; i++) step("pre_reset", 1'b1, rand_pkt(), 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = rand_pkt();
    #2;
    reset   = 1'b0;
    m_rst_n = 1'b0;
    m_clear();
    m_ovf = 0;
    #1;
    check_outputs("async_reset");
    @(posedge clock);
    edge_n++;
    #1;
    check_outputs("reset_mid");
    reset   = 1'b1;
    m_rst_n = 1'b1;
    #1;
    check_outputs("reset_release");
    step("after_reset_push", 1'b1, rand_pkt(), 1'b1, 1'b0);
    repeat (3) step("after_reset", 1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      step("random", 1'($urandom_range(0, 1)), rand_pkt(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    for (int i = 0; i < NP + 2; i++) step("final_drain", 1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_ring.md
Name: axis_packet_ring

Overview:
- Parametrised successor to the fixed-slot packet buffer on the FPGA difftest AXI-Stream path.
- Self-managed circular FIFO of wide packets, built from BRAM slices: internal write/read pointers, valid/ready handshakes on both sides, occupancy and overflow status.
- Sits between the difftest packet packer (upstream) and the AXI-Stream beat serializer (downstream).
- Data width need not be a multiple of the BRAM slice width; the last slice is narrower.

Parameters:
- DATA_WIDTH, 16000, packet width in bits, >= 1.
- NUM_PACKETS, 8, slot count, power of two, >= 2.
- SLICE_WIDTH, 4000, bits per BRAM slice.
- PTR_WIDTH, $clog2(NUM_PACKETS), derived localparam, not overridable.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all packets.
- in_valid  in  1  upstream packet present.
- in_ready  out  1  ring can accept a packet.
- in_data  in  DATA_WIDTH  upstream packet.
- out_valid  out  1  head packet presented.
- out_ready  in  1  downstream consumes head.
- out_data  out  DATA_WIDTH  head packet.
- occupancy  out  PTR_WIDTH+1  packets stored, 0..NUM_PACKETS.
- overflow_cnt  out  32  cycles with in_valid=1 and in_ready=0.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - in_ready=0 while reset is asserted, 1 in the first cycle after release.
  - out_valid=0, occupancy=0, overflow_cnt=0, both pointers=0.
  - out_data is undefined until the first out_valid.
- Push: in_valid&&in_ready at edge T writes in_data to slot wr_ptr in every slice, then wr_ptr wraps modulo NUM_PACKETS.
- Pop: out_valid&&out_ready at edge T advances rd_ptr with wrap.
- in_ready = !(occupancy==NUM_PACKETS), combinational from registered state only. There is no same-cycle pass-through when full.
- occupancy: +1 on push, -1 on pop, unchanged when both occur in the same cycle.
- Read latency:
  - A packet pushed at edge T into an empty ring gives out_valid=1 from cycle T+2. This covers one BRAM write plus one registered read.
  - out_data is the head slot content, stable while out_valid&&!out_ready (AXI-Stream rule).
  - After a pop at edge T, the next packet (if already visible) is on out_data with out_valid=1 in cycle T+1. This gives back-to-back one-per-cycle drain.
  - BRAM read address is rd_ptr+1 when popping, else rd_ptr.
- Visibility rule: a slot written at edge T is not readable before T+1, so it cannot be presented before cycle T+2. Same-slot write and read never collide because in_ready=0 when full.
- out_valid may be 0 while occupancy>0 for at most one cycle after a push into an empty ring, or into a ring whose only other packet was just popped.
- Slicing:
  - NUM_SLICES = ceil(DATA_WIDTH/SLICE_WIDTH).
  - Slice k holds bits [min((k+1)*SLICE_WIDTH, DATA_WIDTH)-1 : k*SLICE_WIDTH]. The last slice is narrower and unused bits are not stored.
  - All slices share pointers and enables.
- flush=1 at an edge:
  - Resets pointers, occupancy and out_valid to 0 at that edge.
  - Discards a coincident push or pop.
  - overflow_cnt is kept.
  - in_ready stays 1.
- overflow_cnt saturates at 32'hFFFFFFFF, no wrap. The upstream packer must hold data when stalled; the counter is diagnostic only.
- Reset asserted mid-transfer: state clears immediately; the in-flight handshake is lost.

Decomposition:
- Package axis_ring_pkg: ring_slices(data_w, slice_w) function (ceil division), slice_lo/slice_hi functions, OVERFLOW_CNT_WIDTH=32.
- One sub-module: axis_ring_slice.
  - Simple dual-port BRAM of NUM_PACKETS x width, registered synchronous read, one write port.
  - Instantiated NUM_SLICES times via generate.
  - Carries a ram_style attribute for block RAM.
- Top level holds pointers, occupancy, valid pipeline and counter.

Test Plan (DATA_WIDTH=10000, SLICE_WIDTH=4000, NUM_PACKETS=4 unless stated):
- Reset, then a single push of pattern A at edge 0, out_ready=1 -> out_valid rises in cycle 2 with out_data=A, all 10000 bits including the 2000-bit last slice; occupancy 1 then 0.
- Push 4 packets P0..P3 with out_ready=0 -> occupancy=4, in_ready=0; hold in_valid 3 more cycles -> overflow_cnt=3, out_data stays P0.
- Full ring, then out_ready=1 for 4 cycles -> P0,P1,P2,P3 on consecutive cycles; out_valid drops after P3; occupancy=0.
- Continuous push and pop for 20 packets (wrap 5 times) -> output order preserved, occupancy constant once steady, no bubbles after the initial 2-cycle latency.
- flush with occupancy=3 coincident with push -> occupancy=0, out_valid=0 next cycle, the pushed packet is never output, overflow_cnt unchanged.
- Assert reset with occupancy=2 mid-stream -> all outputs at reset values within the same cycle; after release the first new push appears 2 cycles later.
